// File: rtl/escalonador_ula.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; response two cycles after transfer.
// One operation in flight at a time: requesters see ready only while idle, and the response holds until consumed.
module escalonador_ula #(
  parameter bit PRIO_INICIAL = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic [3:0]  ctrlULA,
  output logic [31:0] entradaA,
  output logic [31:0] entradaB,
  input  logic [31:0] saida,
  input  logic        zero
);

  typedef enum logic [1:0] {OCIOSO, EXECUTA, RESPONDE} estado_t;

  estado_t estado;
  logic    prio;
  logic    id;
  logic    pronto;
  logic    vence1;
  logic    transf;
  logic    resp_hs;

  // pronto keeps both readies low for the first cycle after reset is released
  assign vence1     = req1_valid && (!req0_valid || prio);
  assign req0_ready = (estado == OCIOSO) && pronto && req0_valid && !vence1;
  assign req1_ready = (estado == OCIOSO) && pronto && vence1;
  assign transf     = req0_ready || req1_ready;
  assign resp_hs    = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= OCIOSO;
      prio        <= PRIO_INICIAL;
      id          <= 1'b0;
      pronto      <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      ctrlULA     <= '0;
      entradaA    <= '0;
      entradaB    <= '0;
    end else begin
      pronto <= 1'b1;
      case (estado)
        OCIOSO: begin
          if (transf) begin
            // the ALU-facing registers double as the operation latch
            id       <= vence1;
            ctrlULA  <= vence1 ? req1_op : req0_op;
            entradaA <= vence1 ? req1_a  : req0_a;
            entradaB <= vence1 ? req1_b  : req0_b;
            estado   <= EXECUTA;
          end
        end
        EXECUTA: begin
          resp_result <= saida;
          resp_zero   <= zero;
          ctrlULA     <= '0;
          entradaA    <= '0;
          entradaB    <= '0;
          resp0_valid <= !id;
          resp1_valid <= id;
          estado      <= RESPONDE;
        end
        RESPONDE: begin
          if (resp_hs) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            prio        <= !id;
            estado      <= OCIOSO;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: doc/escalonador_ula.md
ESCALONADOR_ULA -- requirements
Module: escalonador_ula

Interface
REQ-001 Parameter PRIO_INICIAL, default 0, the requester that holds priority after reset (0 or 1).
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-004 req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1  escalonador accepts requester n's operation this cycle.
REQ-006 req0_op / req1_op  input  4  ALU control code (0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR).
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32 each  operands of requester n.
REQ-008 resp0_valid / resp1_valid  output  1  result for requester n is on resp_result/resp_zero.
REQ-009 resp0_ready / resp1_ready  input  1  requester n consumes the response.
REQ-010 resp_result  output  32  captured ALU result, shared by both requesters.
REQ-011 resp_zero  output  1  captured ALU zero flag.
REQ-012 ctrlULA  output  4  control code driven to the shared ALU.
REQ-013 entradaA, entradaB  output  32 each  operands driven to the shared ALU.
REQ-014 saida  input  32  ALU result (combinational from ctrlULA/entradaA/entradaB).
REQ-015 zero  input  1  ALU zero flag (1 when saida == 0).

Function
REQ-016 The block SHALL implement a three-state FSM: OCIOSO, EXECUTA, RESPONDE.
REQ-017 In OCIOSO, winner = the valid requester if only one is valid; if both are valid, the requester holding priority.
REQ-018 In OCIOSO, reqN_ready SHALL be 1 only for the winner; ready is never asserted outside OCIOSO, and never for both requesters at once.
REQ-019 A transfer occurs when reqN_valid && reqN_ready; the block SHALL latch op, a, b and the winner id, and go to EXECUTA on the next cycle.
REQ-020 In EXECUTA, ctrlULA/entradaA/entradaB SHALL carry the latched op/a/b; at the end of the cycle saida and zero SHALL be captured into resp_result/resp_zero, and the FSM goes to RESPONDE.
REQ-021 In OCIOSO and RESPONDE, ctrlULA, entradaA and entradaB SHALL be driven to 0.
REQ-022 In RESPONDE, respN_valid SHALL be 1 only for the latched id, and resp_result/resp_zero SHALL hold stable until respN_ready.
REQ-023 When respN_valid && respN_ready, the FSM SHALL return to OCIOSO, and priority SHALL pass to the other requester (round-robin).
REQ-024 The other requester's resp_ready is ignored in RESPONDE; no response is lost or duplicated.
REQ-025 Latency: transfer in cycle N produces respN_valid in cycle N+2; maximum throughput is one operation per 3 cycles.
REQ-026 Undefined op codes are forwarded unchanged; the response carries whatever the ALU returns (0 and zero=1 for the standard ALU).
REQ-027 Requester inputs that change while the requester is not granted SHALL NOT affect the operation in flight.
REQ-028 A requester that drops valid before being granted loses its turn without side effects.

Reset
REQ-029 While reset == 0 at a clock edge: FSM = OCIOSO, priority = PRIO_INICIAL, and resp_result, resp_zero, ctrlULA, entradaA and entradaB are all 0.
REQ-030 Reset also clears req0_ready, req1_ready, resp0_valid and resp1_valid to 0; they stay 0 through the first cycle after reset is released.
REQ-031 Reset asserted in EXECUTA or RESPONDE SHALL abort the operation; its response is never issued.

Verification
REQ-032 Single request: req0 op=2, a=5, b=7 after reset -> req0_ready in the transfer cycle; resp0_valid two cycles later with resp_result=12, resp_zero=0.
REQ-033 Contention: req0 and req1 valid together with PRIO_INICIAL=0 -> req0 granted first; after resp0 handshake, req1 granted (round-robin); a further tie grants req0.
REQ-034 Zero flag: req1 op=6, a=b=0x0000_00FF -> resp1_valid with resp_result=0, resp_zero=1; op=7, a=3, b=9 -> resp_result=1, resp_zero=0.
REQ-035 Backpressure: resp0_ready held 0 for 5 cycles -> resp0_valid and resp_result held stable, req1_ready=0 throughout, ALU inputs=0; on release, transfer completes and FSM returns to OCIOSO.
REQ-036 Reset mid-operation: reset=0 during EXECUTA -> next cycle all outputs 0, no respN_valid; the next request completes normally with priority = PRIO_INICIAL.
